ta_adc_merge_cap: RTL and testbench

- Parametrised successor to the fixed 4x14-bit ADC merge path, working in the ADC sample clock domain.
- Packs MERGE_N consecutive ADC samples of ADC_W bits into one wide word.
- Supports run-time decimation, an armed/triggered capture window of programmable length, abort, and a sticky overrange flag.
- Its output feeds the capture memory writer; mem_reset clears that memory.

---
 rtl/ta_adc_merge_cap.sv | 222 ++++++++++++++++++++++
 tb/tb_ta_adc_merge_cap.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ta_adc_merge_cap.sv
// ta_adc_merge_cap
// ----------------
// Packs MERGE_N consecutive ADC samples of ADC_W bits into one wide word for
// the capture memory writer.  Capture is a small arm / trigger / capture
// sequence with run-time decimation (keep 1 of 2^dec_sel samples), a
// programmable capture length in merged words, abort, and a sticky overrange
// flag.  Everything runs on the rising edge of the ADC sample clock.
//
// Ports
//   clk250      ADC sample clock
//   rst         asynchronous, active-low reset
//   adc_data    ADC sample, valid every cycle
//   adc_of      overrange flag for the current sample
//   cap_arm     arm request (acted on in IDLE only)
//   cap_trig    trigger (acted on in ARMED only)
//   cap_abort   abort, highest priority, any state
//   cap_len     capture length in merged words, latched on accepted arm (0 -> 1)
//   dec_sel     decimation select, latched on accepted arm
//   merge_data  packed word, slot k at [k*ADC_W +: ADC_W], slot 0 earliest
//   merge_datv  one-cycle valid strobe for merge_data
//   merge_last  with merge_datv on the final word of a capture
//   word_cnt    words emitted in the current / most recent capture
//   cap_of      sticky overrange flag, cleared on accepted arm
//   capr_rdy    high in IDLE
//   cap_busy    high in ARMED or CAPT
//   mem_reset   one-cycle pulse on accepted arm (clears capture memory)

module ta_adc_merge_cap #(
    parameter int ADC_W   = 14,
    parameter int MERGE_N = 4,
    parameter int LEN_W   = 16
) (
    input  logic                     clk250,
    input  logic                     rst,
    input  logic [ADC_W-1:0]         adc_data,
    input  logic                     adc_of,
    input  logic                     cap_arm,
    input  logic                     cap_trig,
    input  logic                     cap_abort,
    input  logic [LEN_W-1:0]         cap_len,
    input  logic [1:0]               dec_sel,
    output logic [ADC_W*MERGE_N-1:0] merge_data,
    output logic                     merge_datv,
    output logic                     merge_last,
    output logic [LEN_W-1:0]         word_cnt,
    output logic                     cap_of,
    output logic                     capr_rdy,
    output logic                     cap_busy,
    output logic                     mem_reset
);

    localparam int DATA_W = ADC_W * MERGE_N;
    localparam int SLOT_W = (MERGE_N > 2) ? $clog2(MERGE_N) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(MERGE_N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CAPT  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [DATA_W-1:0] merge_data_reg;
    logic              merge_datv_reg;
    logic              merge_last_reg;
    logic [LEN_W-1:0]  word_cnt_reg;
    logic              cap_of_reg;
    logic              mem_reset_reg;
    logic [SLOT_W-1:0] slot_cnt_reg;
    logic [2:0]        dec_cnt_reg;
    logic [1:0]        dec_reg;
    logic [LEN_W-1:0]  len_reg;

    // Holding registers for all slots except the last; the last sample of a
    // word goes straight from adc_data into merge_data.
    logic [ADC_W-1:0]  slot_reg [MERGE_N-1];
    logic [DATA_W-1:0] word_full;

    logic       arm_acc;
    logic       trig_acc;
    logic       take;
    logic       word_done;
    logic       final_word;
    logic [3:0] dec_span;
    logic [2:0] dec_top;

    assign dec_span = 4'd1 << dec_reg;
    assign dec_top  = 3'(dec_span - 4'd1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk250 or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and per-cycle control decodes.  Abort beats everything,
    // so an aborted cycle never takes a sample.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        arm_acc    = 1'b0;
        trig_acc   = 1'b0;
        take       = 1'b0;
        word_done  = 1'b0;
        final_word = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cap_arm && !cap_abort) begin
                    arm_acc    = 1'b1;
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (cap_abort) begin
                    state_next = IDLE;
                end else if (cap_trig) begin
                    trig_acc   = 1'b1;
                    state_next = CAPT;
                end
            end
            CAPT: begin
                if (cap_abort) begin
                    state_next = IDLE;
                end else if (dec_cnt_reg == 3'd0) begin
                    take = 1'b1;
                    if (slot_cnt_reg == SLOT_LAST) begin
                        word_done = 1'b1;
                        // word_cnt_reg still holds the count before this word
                        if (word_cnt_reg == len_reg - LEN_W'(1)) begin
                            final_word = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Slot holding registers and word assembly
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < MERGE_N - 1; gi++) begin : g_slot
        always_ff @(posedge clk250 or negedge rst) begin
            if (!rst) begin
                slot_reg[gi] <= '0;
            end else if (take && slot_cnt_reg == SLOT_W'(gi)) begin
                slot_reg[gi] <= adc_data;
            end
        end
        assign word_full[gi*ADC_W +: ADC_W] = slot_reg[gi];
    end
    assign word_full[(MERGE_N-1)*ADC_W +: ADC_W] = adc_data;

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk250 or negedge rst) begin
        if (!rst) begin
            merge_data_reg <= '0;
            merge_datv_reg <= 1'b0;
            merge_last_reg <= 1'b0;
            word_cnt_reg   <= '0;
            cap_of_reg     <= 1'b0;
            mem_reset_reg  <= 1'b0;
            slot_cnt_reg   <= '0;
            dec_cnt_reg    <= '0;
            dec_reg        <= '0;
            len_reg        <= '0;
        end else begin
            mem_reset_reg  <= arm_acc;
            merge_datv_reg <= word_done;
            merge_last_reg <= final_word;

            if (arm_acc) begin
                cap_of_reg   <= 1'b0;
                word_cnt_reg <= '0;
                len_reg      <= (cap_len == '0) ? LEN_W'(1) : cap_len;
                dec_reg      <= dec_sel;
            end

            if (trig_acc) begin
                slot_cnt_reg <= '0;
                dec_cnt_reg  <= '0;
            end else if (state_reg == CAPT && !cap_abort) begin
                dec_cnt_reg <= (dec_cnt_reg == dec_top) ? 3'd0 : dec_cnt_reg + 3'd1;
                if (take) begin
                    slot_cnt_reg <= (slot_cnt_reg == SLOT_LAST) ? '0
                                                                : slot_cnt_reg + SLOT_W'(1);
                end
            end

            if (take && adc_of) begin
                cap_of_reg <= 1'b1;
            end

            if (word_done) begin
                merge_data_reg <= word_full;
                if (word_cnt_reg != '1) begin
                    word_cnt_reg <= word_cnt_reg + LEN_W'(1);
                end
            end
        end
    end

    assign merge_data = merge_data_reg;
    assign merge_datv = merge_datv_reg;
    assign merge_last = merge_last_reg;
    assign word_cnt   = word_cnt_reg;
    assign cap_of     = cap_of_reg;
    assign mem_reset  = mem_reset_reg;
    assign capr_rdy   = (state_reg == IDLE);
    assign cap_busy   = (state_reg == ARMED) || (state_reg == CAPT);

endmodule

// File: tb/tb_ta_adc_merge_cap.sv
// Directed bench for ta_adc_merge_cap at default parameters.  Each scenario
// restarts a local cycle index t at 0; adc_data follows t as a ramp.  Inputs
// change 1 ns after the rising edge and outputs are checked at that point.

module tb_ta_adc_merge_cap;

    localparam int ADC_W   = 14;
    localparam int MERGE_N = 4;
    localparam int LEN_W   = 16;
    localparam int DW      = ADC_W * MERGE_N;

    logic             clk250;
    logic             rst;
    logic [ADC_W-1:0] adc_data;
    logic             adc_of;
    logic             cap_arm;
    logic             cap_trig;
    logic             cap_abort;
    logic [LEN_W-1:0] cap_len;
    logic [1:0]       dec_sel;
    logic [DW-1:0]    merge_data;
    logic             merge_datv;
    logic             merge_last;
    logic [LEN_W-1:0] word_cnt;
    logic             cap_of;
    logic             capr_rdy;
    logic             cap_busy;
    logic             mem_reset;

    int n_checks = 0;
    int n_errors = 0;
    int t = 0;
    int datv_seen = 0;
    int base;

    ta_adc_merge_cap #(
        .ADC_W  (ADC_W),
        .MERGE_N(MERGE_N),
        .LEN_W  (LEN_W)
    ) dut (
        .clk250    (clk250),
        .rst       (rst),
        .adc_data  (adc_data),
        .adc_of    (adc_of),
        .cap_arm   (cap_arm),
        .cap_trig  (cap_trig),
        .cap_abort (cap_abort),
        .cap_len   (cap_len),
        .dec_sel   (dec_sel),
        .merge_data(merge_data),
        .merge_datv(merge_datv),
        .merge_last(merge_last),
        .word_cnt  (word_cnt),
        .cap_of    (cap_of),
        .capr_rdy  (capr_rdy),
        .cap_busy  (cap_busy),
        .mem_reset (mem_reset)
    );

    initial begin
        clk250 = 1'b0;
        forever #5 clk250 = ~clk250;
    end

    // One line per emitted word
    always @(negedge clk250) begin
        if (merge_datv) begin
            datv_seen = datv_seen + 1;
            $display("word: data=%h last=%b word_cnt=%0d", merge_data, merge_last, word_cnt);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {14'(d), 14'(c), 14'(b), 14'(a)};
    endfunction

    task automatic tick();
        @(posedge clk250);
        #1;
        t = t + 1;
        adc_data = ADC_W'(t);
    endtask

    task automatic start_scn();
        tick();
        t = 0;
        adc_data = '0;
    endtask

    task automatic run_to(input int target);
        while (t < target) tick();
    endtask

    // Arm at t=0 with the given length/decimation and trigger in cycle trig_at
    task automatic arm_and_trig(input logic [LEN_W-1:0] len, input logic [1:0] dec, input int trig_at);
        start_scn();
        cap_len = len;
        dec_sel = dec;
        cap_arm = 1'b1;
        tick();
        cap_arm = 1'b0;
        run_to(trig_at);
        cap_trig = 1'b1;
        tick();
        cap_trig = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        adc_data  = '0;
        adc_of    = 1'b0;
        cap_arm   = 1'b0;
        cap_trig  = 1'b0;
        cap_abort = 1'b0;
        cap_len   = '0;
        dec_sel   = '0;

        // Reset state
        #3;
        check("rst_datv", merge_datv, 0);
        check("rst_data", merge_data, 0);
        check("rst_wcnt", word_cnt, 0);
        check("rst_rdy", capr_rdy, 1);
        check("rst_busy", cap_busy, 0);
        check("rst_memrst", mem_reset, 0);
        repeat (2) @(posedge clk250);
        #3 rst = 1'b1;

        // Scenario 1: dec 0, len 2, arm t0, trig t3
        base = datv_seen;
        start_scn();
        cap_len = 2; dec_sel = 0; cap_arm = 1'b1;
        tick();
        check("s1_memrst_c1", mem_reset, 1);
        check("s1_busy_c1", cap_busy, 1);
        cap_arm = 1'b0;
        run_to(2);
        check("s1_memrst_c2", mem_reset, 0);
        run_to(3);
        cap_trig = 1'b1;
        tick();
        cap_trig = 1'b0;
        run_to(7);
        check("s1_datv_c7", merge_datv, 0);
        run_to(8);
        check("s1_datv_c8", merge_datv, 1);
        check("s1_data_w1", merge_data, pack4(4, 5, 6, 7));
        check("s1_last_w1", merge_last, 0);
        check("s1_wcnt_w1", word_cnt, 1);
        run_to(11);
        check("s1_rdy_c11", capr_rdy, 0);
        run_to(12);
        check("s1_datv_c12", merge_datv, 1);
        check("s1_data_w2", merge_data, pack4(8, 9, 10, 11));
        check("s1_last_w2", merge_last, 1);
        check("s1_rdy_c12", capr_rdy, 1);
        check("s1_wcnt_w2", word_cnt, 2);
        run_to(14);
        check("s1_data_hold", merge_data, pack4(8, 9, 10, 11));
        check("s1_nwords", datv_seen - base, 2);

        // Scenario 2: dec 2, len 1, CAPT starts at sample 20
        base = datv_seen;
        arm_and_trig(1, 2, 19);
        run_to(32);
        check("s2_datv_c32", merge_datv, 0);
        run_to(33);
        check("s2_datv_c33", merge_datv, 1);
        check("s2_data", merge_data, pack4(20, 24, 28, 32));
        check("s2_last", merge_last, 1);
        check("s2_rdy", capr_rdy, 1);
        run_to(40);
        check("s2_nwords", datv_seen - base, 1);

        // Scenario 3: as scenario 1, abort at 6th CAPT sample (cycle 9)
        base = datv_seen;
        arm_and_trig(2, 0, 3);
        run_to(8);
        check("s3_data_w1", merge_data, pack4(4, 5, 6, 7));
        run_to(9);
        cap_abort = 1'b1;
        tick();
        cap_abort = 1'b0;
        check("s3_rdy", capr_rdy, 1);
        check("s3_busy", cap_busy, 0);
        check("s3_wcnt", word_cnt, 1);
        run_to(16);
        check("s3_nwords", datv_seen - base, 1);

        // Scenario 4: cap_len 0 behaves as 1
        base = datv_seen;
        arm_and_trig(0, 0, 3);
        run_to(8);
        check("s4_datv", merge_datv, 1);
        check("s4_last", merge_last, 1);
        check("s4_data", merge_data, pack4(4, 5, 6, 7));
        check("s4_wcnt", word_cnt, 1);
        run_to(14);
        check("s4_nwords", datv_seen - base, 1);
        check("s4_rdy", capr_rdy, 1);

        // Scenario 5a: overrange on a decimated-away sample (dec 1, taken 4,6,8,10)
        arm_and_trig(1, 1, 3);
        run_to(5);
        adc_of = 1'b1;
        tick();
        adc_of = 1'b0;
        run_to(11);
        check("s5a_data", merge_data, pack4(4, 6, 8, 10));
        run_to(12);
        check("s5a_capof", cap_of, 0);

        // Scenario 5b: overrange on a taken sample
        arm_and_trig(1, 0, 3);
        run_to(5);
        adc_of = 1'b1;
        tick();
        adc_of = 1'b0;
        run_to(9);
        check("s5b_capof", cap_of, 1);

        // Scenario 5c: next accepted arm clears cap_of with mem_reset
        start_scn();
        check("s5c_capof_hold", cap_of, 1);
        cap_len = 1; dec_sel = 0; cap_arm = 1'b1;
        tick();
        cap_arm = 1'b0;
        check("s5c_memrst", mem_reset, 1);
        check("s5c_capof_clr", cap_of, 0);
        cap_abort = 1'b1;
        tick();
        cap_abort = 1'b0;
        check("s5c_rdy", capr_rdy, 1);

        // Scenario 6a: trigger in IDLE ignored
        start_scn();
        cap_trig = 1'b1;
        tick();
        tick();
        check("s6_trig_idle_rdy", capr_rdy, 1);
        check("s6_trig_idle_busy", cap_busy, 0);
        cap_trig = 1'b0;

        // Scenario 6b: arm and abort together in IDLE
        cap_arm = 1'b1; cap_abort = 1'b1;
        tick();
        cap_arm = 1'b0; cap_abort = 1'b0;
        check("s6_armabort_memrst", mem_reset, 0);
        check("s6_armabort_rdy", capr_rdy, 1);

        // Scenario 6c: arm ignored in CAPT, then reset mid-capture
        arm_and_trig(3, 0, 3);
        run_to(5);
        adc_of = 1'b1;
        tick();
        adc_of = 1'b0;
        cap_arm = 1'b1;
        tick();
        cap_arm = 1'b0;
        check("s6_capt_arm_memrst", mem_reset, 0);
        check("s6_capt_arm_busy", cap_busy, 1);
        run_to(8);
        check("s6_w1_datv", merge_datv, 1);
        check("s6_w1_capof", cap_of, 1);
        run_to(10);
        base = datv_seen;
        #3 rst = 1'b0;
        #1;
        check("s6_rst_rdy", capr_rdy, 1);
        check("s6_rst_busy", cap_busy, 0);
        check("s6_rst_wcnt", word_cnt, 0);
        check("s6_rst_data", merge_data, 0);
        check("s6_rst_capof", cap_of, 0);
        check("s6_rst_datv", merge_datv, 0);
        check("s6_rst_last", merge_last, 0);
        repeat (3) @(posedge clk250);
        #3 rst = 1'b1;
        repeat (6) @(posedge clk250);
        #1;
        check("s6_rst_nwords", datv_seen - base, 0);
        check("s6_rst_idle", capr_rdy, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
